// File: rtl/mode_sequencer.sv
// mode_sequencer: front-panel mode controller for the watch.
// Synchronises the UP/DOWN/ESC buttons, steps a one-hot mode register over
// N_MODES function blocks (skipping disabled ones), muxes the active block's
// display word, and keeps a sticky aggregated alarm flag cleared by ESC.
// Optional build macro ALARM_JUMP_EN: an alarm rising edge forces the mode
// to the lowest-index block whose alarm rose, overriding any button step.
module mode_sequencer #(
    parameter int N_MODES    = 7,
    parameter int OUT_W      = 48,
    parameter int RESET_MODE = 1,
    parameter int IDX_W      = $clog2(N_MODES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       up_n,
    input  logic                       down_n,
    input  logic                       esc_n,
    input  logic [N_MODES-1:0]         mode_en,
    input  logic [N_MODES-1:0]         norm,
    input  logic [N_MODES-1:0]         alarm_in,
    input  logic [N_MODES*OUT_W-1:0]   data_in,
    output logic                       up,
    output logic                       down,
    output logic                       esc,
    output logic [N_MODES-1:0]         mode_oh,
    output logic [IDX_W-1:0]           mode_idx,
    output logic [OUT_W-1:0]           data_out,
    output logic                       alm
);

    logic up_sync_p0, up_sync_p1, up_lvl_p2;
    logic dn_sync_p0, dn_sync_p1, dn_lvl_p2;
    logic esc_sync_p0, esc_sync_p1, esc_lvl_p2;
    logic up_press, down_press, esc_press;
    logic [IDX_W-1:0]   idx_next;
    logic [OUT_W-1:0]   sel_word;
    logic [N_MODES-1:0] alarm_d;
    logic [N_MODES-1:0] alarm_rise;
    logic [N_MODES-1:0] pending;
    logic [N_MODES-1:0] pending_next;

    // First enabled mode above cur (wrapping); cur itself if none.
    function automatic logic [IDX_W-1:0] next_up_idx(input logic [IDX_W-1:0] cur,
                                                     input logic [N_MODES-1:0] en);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] j;
        logic             found;
        int               t;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < N_MODES; k++) begin
            t = int'(cur) + k;
            if (t >= N_MODES) t = t - N_MODES;
            j = IDX_W'(t);
            if (!found && en[j]) begin
                found = 1'b1;
                res   = j;
            end
        end
        return res;
    endfunction

    // First enabled mode below cur (wrapping); cur itself if none.
    function automatic logic [IDX_W-1:0] next_down_idx(input logic [IDX_W-1:0] cur,
                                                       input logic [N_MODES-1:0] en);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] j;
        logic             found;
        int               t;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < N_MODES; k++) begin
            t = int'(cur) - k;
            if (t < 0) t = t + N_MODES;
            j = IDX_W'(t);
            if (!found && en[j]) begin
                found = 1'b1;
                res   = j;
            end
        end
        return res;
    endfunction

`ifdef ALARM_JUMP_EN
    // Lowest set bit index of a non-zero vector.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_MODES-1:0] v);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = N_MODES - 1; i >= 0; i--) begin
            if (v[i]) res = IDX_W'(i);
        end
        return res;
    endfunction
`endif

    // Stage p0/p1: two-flop synchronisers on the raw pins (idle = released = 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_sync_p0  <= 1'b1;
            up_sync_p1  <= 1'b1;
            dn_sync_p0  <= 1'b1;
            dn_sync_p1  <= 1'b1;
            esc_sync_p0 <= 1'b1;
            esc_sync_p1 <= 1'b1;
        end else begin
            up_sync_p0  <= up_n;
            up_sync_p1  <= up_sync_p0;
            dn_sync_p0  <= down_n;
            dn_sync_p1  <= dn_sync_p0;
            esc_sync_p0 <= esc_n;
            esc_sync_p1 <= esc_sync_p0;
        end
    end

    assign up   = ~up_sync_p1;
    assign down = ~dn_sync_p1;
    assign esc  = ~esc_sync_p1;

    // Stage p2: delayed active-high levels for single-cycle press detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_lvl_p2  <= 1'b0;
            dn_lvl_p2  <= 1'b0;
            esc_lvl_p2 <= 1'b0;
        end else begin
            up_lvl_p2  <= up;
            dn_lvl_p2  <= down;
            esc_lvl_p2 <= esc;
        end
    end

    assign up_press   = up & ~up_lvl_p2;
    assign down_press = down & ~dn_lvl_p2;
    assign esc_press  = esc & ~esc_lvl_p2;
    assign alarm_rise = alarm_in & ~alarm_d;

    // Next mode: disabled-mode escape first, then gated button step, alarm jump on top.
    always_comb begin
        idx_next = mode_idx;
        if (!mode_en[mode_idx]) begin
            idx_next = next_up_idx(mode_idx, mode_en);
        end else if (|(mode_oh & norm)) begin
            if (up_press && !down_press) begin
                idx_next = next_up_idx(mode_idx, mode_en);
            end else if (down_press && !up_press) begin
                idx_next = next_down_idx(mode_idx, mode_en);
            end
        end
`ifdef ALARM_JUMP_EN
        if (|alarm_rise) begin
            idx_next = lowest_set(alarm_rise);
        end
`endif
    end

    // Mode register: index and one-hot always written from the same next value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_idx <= IDX_W'(RESET_MODE);
            mode_oh  <= N_MODES'(1) << RESET_MODE;
        end else begin
            mode_idx <= idx_next;
            mode_oh  <= N_MODES'(1) << idx_next;
        end
    end

    // Channel select from the registered mode index.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_MODES; i++) begin
            if (mode_idx == IDX_W'(i)) sel_word = data_in[i*OUT_W +: OUT_W];
        end
    end

    // Display word lags mode_idx by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out <= '0;
        else        data_out <= sel_word;
    end

    // Pending alarms: ESC clears, a coincident rising edge still sets its bit.
    always_comb begin
        pending_next = pending;
        if (esc_press) pending_next = '0;
        pending_next = pending_next | alarm_rise;
    end

    // Alarm edge history, pending bits and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_d <= '0;
            pending <= '0;
            alm     <= 1'b0;
        end else begin
            alarm_d <= alarm_in;
            pending <= pending_next;
            alm     <= |pending_next;
        end
    end

endmodule
